oam_dma: RTL and testbench

//  Sprite DMA engine for the $4014 register. Detects a CPU write to OAMDMA,

---
 rtl/nes_pkg.sv | 18 +
 rtl/oam_dma.sv | 100 ++++++++++
 tb/tb_oam_dma.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES bus definitions: DMA state encoding and the register addresses
// that both the sprite DMA engine and the databus address decode rely on.
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN0 = 3'd1,
        ST_ALIGN1 = 3'd2,
        ST_READ   = 3'd3,
        ST_FETCH  = 3'd4,
        ST_WRITE  = 3'd5
    } dma_state_t;

    localparam logic [15:0] TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_ADDR  = 16'h2004;
    localparam int          NBYTES    = 256;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to OAMDMA stalls the CPU and copies one page
// of CPU memory, byte by byte, into the PPU OAMDATA port.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR_P = TRIG_ADDR,
    parameter logic [15:0] OAM_ADDR_P  = OAM_ADDR,
    parameter int          NBYTES_P    = NBYTES
) (
    input  logic        Clk,
    input  logic        Res_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_dout,
    input  logic        odd_or_even,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_wr_n,
    output logic [7:0]  dma_wdata
);

    localparam logic [7:0] LAST_IDX = 8'(NBYTES_P - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge Clk or negedge Res_n) begin
        if (!Res_n) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_d     = data_q;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        dma_addr   = {page_q, idx_q};
        dma_wr_n   = 1'b1;
        dma_wdata  = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                // Outputs parked at their reset values so the bus mux sees
                // a quiet, write-free source while the CPU owns the bus.
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                dma_addr   = 16'h0000;
                if (!cpu_wr_n && cpu_addr == TRIG_ADDR_P) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = ST_ALIGN0;
                end
            end
            ST_ALIGN0: begin
                state_d = odd_or_even ? ST_ALIGN1 : ST_READ;
            end
            ST_ALIGN1: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // Read data returns one cycle after the address was issued.
                data_d  = bus_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                dma_addr  = OAM_ADDR_P;
                dma_wr_n  = 1'b0;
                dma_wdata = data_q;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: walks the expected cycle schedule of each
// transfer against a 1-cycle-latency RAM model holding byte[i] = i ^ 8'hA5.
module tb_oam_dma;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_wr_n;
    logic [7:0]  cpu_dout;
    logic        odd_or_even;
    logic [7:0]  bus_rdata;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_wr_n;
    logic [7:0]  dma_wdata;

    int tests = 0;
    int fails = 0;

    oam_dma dut (
        .Clk        (clk),
        .Res_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_dout   (cpu_dout),
        .odd_or_even(odd_or_even),
        .bus_rdata  (bus_rdata),
        .cpu_rdy    (cpu_rdy),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_wr_n   (dma_wr_n),
        .dma_wdata  (dma_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read of the low address byte.
    always @(posedge clk) bus_rdata <= dma_addr[7:0] ^ 8'hA5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {12'h0, cpu_rdy, dma_active, dma_wr_n, dma_addr},
                 {12'h0, 1'b1, 1'b0, 1'b1, 16'h0000});
        chk({tag, "_wdata"}, {24'h0, dma_wdata}, 32'h0);
    endtask

    // Trigger a transfer and check every stall cycle against the hand schedule.
    // abort_byte >= 0 pulls reset during the FETCH cycle of that byte.
    // inject=1 issues a $4014 write during byte 50 that must be ignored.
    task automatic run_xfer(input logic [7:0] page, input logic odd,
                            input int abort_byte, input logic inject);
        int n_align;
        int stall;
        n_align = odd ? 2 : 1;
        stall   = 0;
        @(negedge clk);
        cpu_addr    = 16'h4014;
        cpu_wr_n    = 1'b0;
        cpu_dout    = page;
        odd_or_even = odd;
        for (int a = 0; a < n_align; a++) begin
            @(negedge clk);
            if (a == 0) begin
                cpu_wr_n = 1'b1;
                cpu_addr = 16'h0000;
            end
            chk("align", {29'h0, cpu_rdy, dma_active, dma_wr_n}, {29'h0, 3'b011});
            if (!cpu_rdy) stall++;
        end
        for (int k = 0; k < 256; k++) begin
            for (int ph = 0; ph < 3; ph++) begin
                @(negedge clk);
                if (!cpu_rdy) stall++;
                if (ph < 2) begin
                    chk(ph == 0 ? "read" : "fetch",
                        {12'h0, cpu_rdy, dma_active, dma_wr_n, dma_addr},
                        {12'h0, 1'b0, 1'b1, 1'b1, page, k[7:0]});
                end else begin
                    chk("write", {12'h0, cpu_rdy, dma_active, dma_wr_n, dma_addr},
                                 {12'h0, 1'b0, 1'b1, 1'b0, 16'h2004});
                    chk("wdata", {24'h0, dma_wdata}, {24'h0, k[7:0] ^ 8'hA5});
                    #4;
                    chk("wdata_hold", {24'h0, dma_wdata}, {24'h0, k[7:0] ^ 8'hA5});
                end
                if (inject && k == 50 && ph == 0) begin
                    cpu_addr = 16'h4014;
                    cpu_wr_n = 1'b0;
                    cpu_dout = 8'h55;
                end
                if (inject && k == 50 && ph == 1) begin
                    cpu_addr = 16'h0000;
                    cpu_wr_n = 1'b1;
                end
                if (k == abort_byte && ph == 1) begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle("abort");
                    repeat (3) begin
                        @(negedge clk);
                        chk_idle("abort_hold");
                    end
                    rst_n = 1'b1;
                    repeat (4) begin
                        @(negedge clk);
                        chk_idle("abort_after");
                    end
                    return;
                end
            end
        end
        chk("stall_cycles", stall, 768 + n_align);
        @(negedge clk);
        chk_idle("done");
        repeat (3) begin
            @(negedge clk);
            chk_idle("done_hold");
        end
        $display("[TB] transfer page=%02h odd=%0d inject=%0d stall=%0d", page, odd, inject, stall);
    endtask

    logic [15:0] nt_addr [4];
    logic        nt_wr_n [4];

    initial begin
        rst_n       = 1'b0;
        cpu_addr    = 16'h0000;
        cpu_wr_n    = 1'b1;
        cpu_dout    = 8'h00;
        odd_or_even = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        $display("[TB] reset checked");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        run_xfer(8'h02, 1'b0, -1, 1'b0);
        run_xfer(8'h02, 1'b1, -1, 1'b0);
        run_xfer(8'hFF, 1'b0, -1, 1'b0);
        run_xfer(8'h03, 1'b1, 100, 1'b0);
        $display("[TB] reset at byte 100 checked");
        run_xfer(8'h03, 1'b0, -1, 1'b0);
        run_xfer(8'h04, 1'b0, -1, 1'b1);

        nt_addr[0] = 16'h4014; nt_wr_n[0] = 1'b1;
        nt_addr[1] = 16'h4013; nt_wr_n[1] = 1'b0;
        nt_addr[2] = 16'h4015; nt_wr_n[2] = 1'b0;
        nt_addr[3] = 16'h2004; nt_wr_n[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_addr = nt_addr[i];
            cpu_wr_n = nt_wr_n[i];
            cpu_dout = 8'h07;
            @(negedge clk);
            cpu_addr = 16'h0000;
            cpu_wr_n = 1'b1;
            chk_idle("non_trigger");
            @(negedge clk);
            chk_idle("non_trigger_hold");
            $display("[TB] non-trigger addr=%04h wr_n=%0d", nt_addr[i], nt_wr_n[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
